// File: rtl/rsa_key_engine.sv
// RSA key engine: from primes P, Q and an exponent e, forms N = P*Q and
// d = e^-1 mod (P-1)(Q-1) using a shift-add multiplier and an iterative Euclid.
module rsa_key_engine #(
    parameter int WORD_WIDTH = 32,
    parameter int DEFAULT_E  = 65537
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD_WIDTH/2-1:0]   p,
    input  logic [WORD_WIDTH/2-1:0]   q,
    input  logic [WORD_WIDTH-1:0]     e_in,
    input  logic                      use_default_e,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [WORD_WIDTH-1:0]     N,
    output logic [WORD_WIDTH-1:0]     d,
    output logic [WORD_WIDTH-1:0]     e
);

    localparam int W  = WORD_WIDTH;
    localparam int H  = WORD_WIDTH / 2;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] DEF_E = W'(DEFAULT_E);

    typedef enum logic [2:0] {
        IDLE, CHECK, MULT, EUC_DIV, EUC_UPD, FIX, FINISH, FAIL
    } state_t;

    state_t state, nstate;

    logic [H-1:0]        p_r, q_r;
    logic [H-1:0]        b_n, b_phi;
    logic [W-1:0]        a_n, a_phi;
    logic [W-1:0]        n_acc, phi_acc;
    logic [W-1:0]        r0, r1, dq, rm;
    logic signed [W:0]   t0, t1, prod;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        n_r, d_r, e_r;
    logic                done_r, err_r;
    logic [1:0]          code_r;

    logic                bad_p, bad_e, e_big;
    logic                mult_last, div_last, qbit;
    logic [W-1:0]        n_nx, phi_nx;
    logic [W:0]          rm_sh, rm_nx;
    logic signed [W:0]   prod_nx, d_fix;

    // Datapath helpers: multiplier step, divider step, final d correction
    always_comb begin
        bad_p     = (p_r < H'(3)) || (q_r < H'(3)) || !p_r[0] || !q_r[0]
                    || (p_r == q_r);
        bad_e     = !e_r[0] || (e_r < W'(3));
        n_nx      = n_acc + (b_n[0] ? a_n : '0);
        phi_nx    = phi_acc + (b_phi[0] ? a_phi : '0);
        e_big     = e_r >= phi_nx;
        mult_last = cnt == CW'(H - 1);
        div_last  = cnt == CW'(W - 1);
        rm_sh     = {rm, dq[W-1]};
        qbit      = rm_sh >= {1'b0, r1};
        rm_nx     = qbit ? (rm_sh - {1'b0, r1}) : rm_sh;
        prod_nx   = (prod <<< 1) + (qbit ? t1 : '0);
        d_fix     = t0[W] ? (t0 + $signed({1'b0, phi_acc})) : t0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state and busy decode
    always_comb begin
        nstate = state;
        busy   = 1'b0;
        unique case (state)
            IDLE:    if (start) nstate = CHECK;
            CHECK: begin
                busy   = 1'b1;
                nstate = (bad_p || bad_e) ? FAIL : MULT;
            end
            MULT: begin
                busy = 1'b1;
                if (mult_last) nstate = e_big ? FAIL : EUC_DIV;
            end
            EUC_DIV: begin
                busy = 1'b1;
                if (div_last) nstate = EUC_UPD;
            end
            EUC_UPD: begin
                busy   = 1'b1;
                nstate = (rm == '0) ? FIX : EUC_DIV;
            end
            FIX: begin
                busy   = 1'b1;
                nstate = (r0 != W'(1)) ? FAIL : FINISH;
            end
            FINISH:  nstate = IDLE;
            FAIL:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Operand capture, multiply, Euclid iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r     <= '0;
            q_r     <= '0;
            b_n     <= '0;
            b_phi   <= '0;
            a_n     <= '0;
            a_phi   <= '0;
            n_acc   <= '0;
            phi_acc <= '0;
            r0      <= '0;
            r1      <= '0;
            dq      <= '0;
            rm      <= '0;
            t0      <= '0;
            t1      <= '0;
            prod    <= '0;
            cnt     <= '0;
            n_r     <= '0;
            d_r     <= '0;
            e_r     <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        p_r     <= p;
                        q_r     <= q;
                        e_r     <= use_default_e ? DEF_E : e_in;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        code_r  <= 2'd0;
                        n_r     <= '0;
                        d_r     <= '0;
                        n_acc   <= '0;
                        phi_acc <= '0;
                        cnt     <= '0;
                    end
                end
                CHECK: begin
                    a_n   <= {{H{1'b0}}, p_r};
                    b_n   <= q_r;
                    a_phi <= {{H{1'b0}}, p_r - H'(1)};
                    b_phi <= q_r - H'(1);
                    cnt   <= '0;
                    if (bad_p) begin
                        err_r  <= 1'b1;
                        code_r <= 2'd1;
                    end else if (bad_e) begin
                        err_r  <= 1'b1;
                        code_r <= 2'd2;
                    end
                end
                MULT: begin
                    n_acc   <= n_nx;
                    phi_acc <= phi_nx;
                    a_n     <= a_n << 1;
                    a_phi   <= a_phi << 1;
                    b_n     <= b_n >> 1;
                    b_phi   <= b_phi >> 1;
                    cnt     <= cnt + CW'(1);
                    if (mult_last) begin
                        if (e_big) begin
                            err_r  <= 1'b1;
                            code_r <= 2'd2;
                        end else begin
                            r0   <= phi_nx;
                            r1   <= e_r;
                            t0   <= '0;
                            t1   <= (W+1)'(1);
                            dq   <= phi_nx;
                            rm   <= '0;
                            prod <= '0;
                            cnt  <= '0;
                        end
                    end
                end
                EUC_DIV: begin
                    rm   <= rm_nx[W-1:0];
                    dq   <= {dq[W-2:0], qbit};
                    prod <= prod_nx;
                    cnt  <= cnt + CW'(1);
                end
                EUC_UPD: begin
                    r0   <= r1;
                    r1   <= rm;
                    t0   <= t1;
                    t1   <= t0 - prod;
                    dq   <= r1;
                    rm   <= '0;
                    prod <= '0;
                    cnt  <= '0;
                end
                FIX: begin
                    if (r0 != W'(1)) begin
                        err_r  <= 1'b1;
                        code_r <= 2'd3;
                    end else begin
                        d_r    <= d_fix[W-1:0];
                        n_r    <= n_acc;
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = done_r;
    assign error    = err_r;
    assign err_code = code_r;
    assign N        = n_r;
    assign d        = d_r;
    assign e        = e_r;

endmodule
